// File: rtl/gpio_bank_pkg.sv
// ---------------------------------------------------------------------------
// gpio_bank_pkg
//   Shared definitions for the memory-mapped GPIO bank: register offsets
//   relative to BASE_ADDR, the register-select enum used by the decoder and
//   the size of the register window.
// ---------------------------------------------------------------------------
package gpio_bank_pkg;

  // Register offsets from BASE_ADDR.
  localparam logic [2:0] OFF_OUT   = 3'd0;
  localparam logic [2:0] OFF_DIR   = 3'd1;
  localparam logic [2:0] OFF_IN    = 3'd2;
  localparam logic [2:0] OFF_IEN   = 3'd3;
  localparam logic [2:0] OFF_ISTAT = 3'd4;

  // Number of registers in the window; offsets 0..NUM_REGS-1 are hits.
  localparam int unsigned NUM_REGS = 5;

  typedef enum logic [2:0] {
    REG_OUT   = OFF_OUT,
    REG_DIR   = OFF_DIR,
    REG_IN    = OFF_IN,
    REG_IEN   = OFF_IEN,
    REG_ISTAT = OFF_ISTAT
  } reg_sel_e;

endpackage : gpio_bank_pkg

// File: rtl/gpio_bank_if.sv
// ---------------------------------------------------------------------------
// gpio_bank_if
//   CPU-side a/d bus of the GPIO bank.
//   a        : bus address            (master -> slave)
//   d        : write data             (master -> slave)
//   we       : write strobe           (master -> slave)
//   re       : read strobe            (master -> slave)
//   rd_data  : registered read data   (slave -> master)
//   rd_valid : one-cycle read pulse   (slave -> master)
// ---------------------------------------------------------------------------
interface gpio_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (output a, d, we, re, input  rd_data, rd_valid);
  modport slave  (input  a, d, we, re, output rd_data, rd_valid);
endinterface : gpio_bank_if

// File: rtl/gpio_sync_edge.sv
// ---------------------------------------------------------------------------
// gpio_sync_edge
//   Two-flop synchroniser for asynchronous pin levels followed by a one-flop
//   history register for rising-edge detection.
//   CLK    : system clock
//   RST    : synchronous active-high reset (all stages cleared)
//   pin_i  : asynchronous pin levels
//   sync_o : synchronised levels (second stage)
//   rise_o : one-cycle pulse per bit on a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module gpio_sync_edge #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] pin_i,
  output logic [DATA_W-1:0] sync_o,
  output logic [DATA_W-1:0] rise_o
);

  logic [DATA_W-1:0] sync1_q;
  logic [DATA_W-1:0] sync2_q;
  logic [DATA_W-1:0] prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the three stages into one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync_o = sync2_q;
  // A pin held high through reset shows up as a rising edge, because the
  // history register restarts from 0.
  assign rise_o = sync2_q & ~prev_q;

endmodule : gpio_sync_edge

// File: rtl/gpio_bank.sv
// ---------------------------------------------------------------------------
// gpio_bank
//   Memory-mapped GPIO bank decoded at BASE_ADDR..BASE_ADDR+4 on the CPU a/d
//   bus. Registers: OUT (R/W), DIR (R/W), IN (RO, synchronised pins),
//   IRQ_EN (R/W), IRQ_STAT (R/W1C, set by rising pin edges).
//   CLK    : system clock, all logic on rising edge
//   RST    : synchronous active-high reset
//   bus    : slave side of the CPU bus (a, d, we, re, rd_data, rd_valid)
//   pin_in : asynchronous external pin levels
//   out    : OUT register, driven to the pins
//   oe     : DIR register, 1 = pin driven by out
//   irq    : level interrupt, |(IRQ_STAT & IRQ_EN)
// ---------------------------------------------------------------------------
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'hABCD,
  parameter int                LEGACY    = 0
) (
  input  logic              CLK,
  input  logic              RST,
  gpio_bank_if.slave        bus,
  input  logic [DATA_W-1:0] pin_in,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] oe,
  output logic              irq
);

  // -------------------------------------------------------------------------
  // Input synchroniser and edge detector
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] pin_sync;
  logic [DATA_W-1:0] pin_rise;

  gpio_sync_edge #(.DATA_W(DATA_W)) u_sync_edge (
    .CLK    (CLK),
    .RST    (RST),
    .pin_i  (pin_in),
    .sync_o (pin_sync),
    .rise_o (pin_rise)
  );

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] offset;
  logic              hit;
  reg_sel_e          sel;

  // The subtraction may wrap for a < BASE_ADDR, so the explicit compare
  // keeps addresses below the window from aliasing into it.
  assign offset = bus.a - BASE_ADDR;
  assign hit    = (bus.a >= BASE_ADDR) && (offset < ADDR_W'(NUM_REGS));
  assign sel    = reg_sel_e'(offset[2:0]);

  logic wr_out, wr_dir, wr_ien, wr_istat;

  // In legacy mode any hit on OUT writes it, mimicking the old latch that
  // had no write strobe.
  assign wr_out   = hit && (sel == REG_OUT) && (bus.we || (LEGACY != 0));
  assign wr_dir   = hit && (sel == REG_DIR)   && bus.we;
  assign wr_ien   = hit && (sel == REG_IEN)   && bus.we;
  assign wr_istat = hit && (sel == REG_ISTAT) && bus.we;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] out_q,     out_d;
  logic [DATA_W-1:0] dir_q,     dir_d;
  logic [DATA_W-1:0] ien_q,     ien_d;
  logic [DATA_W-1:0] istat_q,   istat_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_mux;

  // Read mux sees the pre-edge register values, so a read and a write to
  // the same register in one cycle returns the old contents.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    rd_mux = '0;
    case (sel)
      REG_OUT:   rd_mux = out_q;
      REG_DIR:   rd_mux = dir_q;
      REG_IN:    rd_mux = pin_sync;
      REG_IEN:   rd_mux = ien_q;
      REG_ISTAT: rd_mux = istat_q;
      default:   rd_mux = '0;
    endcase
  end

  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    ien_d      = ien_q;
    istat_d    = istat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = bus.re;

    if (wr_out) out_d = bus.d;
    if (wr_dir) dir_d = bus.d;
    if (wr_ien) ien_d = bus.d;
    if (wr_istat) istat_d = istat_q & ~bus.d;
    // Applied after the clear so a fresh edge wins over a same-cycle W1C.
    istat_d = istat_d | pin_rise;

    // Misses still complete the read, returning zero.
    if (bus.re) rd_data_d = hit ? rd_mux : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q      <= '0;
      dir_q      <= '0;
      ien_q      <= '0;
      istat_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      ien_q      <= ien_d;
      istat_q    <= istat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out          = out_q;
  assign oe           = dir_q;
  assign irq          = |(istat_q & ien_q);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule : gpio_bank

// File: tb/tb_gpio_bank.sv
// ---------------------------------------------------------------------------
// tb_gpio_bank
//   Directed bench for gpio_bank. A default instance (LEGACY=0) is the main
//   target; a second LEGACY=1 instance shares the same bus stimulus and is
//   only inspected for the legacy OUT-write behaviour.
// ---------------------------------------------------------------------------
module tb_gpio_bank;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'hABCD;

  logic              CLK;
  logic              RST;
  logic [DATA_W-1:0] pin_in;
  logic [DATA_W-1:0] out, oe, out_l, oe_l;
  logic              irq, irq_l;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif   ();
  gpio_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif_l ();

  assign bif_l.a  = bif.a;
  assign bif_l.d  = bif.d;
  assign bif_l.we = bif.we;
  assign bif_l.re = bif.re;

  gpio_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .LEGACY(0)) dut (
    .CLK(CLK), .RST(RST), .bus(bif), .pin_in(pin_in),
    .out(out), .oe(oe), .irq(irq)
  );

  gpio_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .LEGACY(1)) dut_l (
    .CLK(CLK), .RST(RST), .bus(bif_l), .pin_in(pin_in),
    .out(out_l), .oe(oe_l), .irq(irq_l)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven
  // 1 ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic we, input logic re);
    bif.a  = a;
    bif.d  = d;
    bif.we = we;
    bif.re = re;
  endtask

  task automatic idle();
    bus(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    RST    = 1'b1;
    pin_in = '0;
    idle();
    tick();
    tick();
    check("rst_out",      out,          32'h0);
    check("rst_oe",       oe,           32'h0);
    check("rst_irq",      {31'h0, irq}, 32'h0);
    check("rst_rd_valid", {31'h0, bif.rd_valid}, 32'h0);
    check("rst_rd_data",  bif.rd_data,  32'h0);
    RST = 1'b0;

    // Legacy decode: address below the window never hits.
    bus(32'h1, 32'h8, 1'b0, 1'b0);
    tick();
    check("leg_miss_out_l", out_l, 32'h0);
    check("leg_miss_out",   out,   32'h0);
    bus(BASE, 32'h8, 1'b0, 1'b0);
    tick();
    check("leg_hit_out_l",  out_l, 32'h8);
    check("nowe_hit_out",   out,   32'h0);
    bus(BASE, 32'h8, 1'b1, 1'b0);
    tick();
    check("we_hit_out",     out,   32'h8);

    // DIR write and readback.
    bus(BASE + 1, 32'hF0F0_0F0F, 1'b1, 1'b0);
    tick();
    check("dir_oe", oe, 32'hF0F0_0F0F);
    bus(BASE + 1, 32'h0, 1'b0, 1'b1);
    tick();
    check("dir_rd_valid", {31'h0, bif.rd_valid}, 32'h1);
    check("dir_rd_data",  bif.rd_data, 32'hF0F0_0F0F);
    idle();
    tick();
    check("dir_rd_valid_drop", {31'h0, bif.rd_valid}, 32'h0);
    check("dir_rd_data_hold",  bif.rd_data, 32'hF0F0_0F0F);

    // Read of an unmapped offset completes with zero.
    bus(BASE + 7, 32'h0, 1'b0, 1'b1);
    tick();
    check("miss_rd_valid", {31'h0, bif.rd_valid}, 32'h1);
    check("miss_rd_data",  bif.rd_data, 32'h0);

    // Writes to IN are ignored and touch nothing else.
    bus(BASE + 2, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    bus(BASE + 2, 32'h0, 1'b0, 1'b1);
    tick();
    check("in_wr_ignored", bif.rd_data, 32'h0);
    check("in_wr_out",     out, 32'h8);
    check("in_wr_oe",      oe,  32'hF0F0_0F0F);

    // Same-cycle read and write returns the pre-write value.
    bus(BASE, 32'h55, 1'b1, 1'b1);
    tick();
    check("rw_same_rd_old", bif.rd_data, 32'h8);
    check("rw_same_out",    out, 32'h55);

    // Enable bit3 interrupt, then raise pin 3 before edge k.
    bus(BASE + 3, 32'h8, 1'b1, 1'b0);
    tick();
    check("ien_irq_idle", {31'h0, irq}, 32'h0);
    idle();
    pin_in[3] = 1'b1;
    tick();                                   // edge k
    bus(BASE + 2, 32'h0, 1'b0, 1'b1);
    tick();                                   // edge k+1
    check("sync_k1_in",  bif.rd_data & 32'h8, 32'h0);
    check("sync_k1_irq", {31'h0, irq}, 32'h0);
    tick();                                   // edge k+2
    check("sync_k2_in",  bif.rd_data & 32'h8, 32'h8);
    check("sync_k2_irq", {31'h0, irq}, 32'h1);
    bus(BASE + 4, 32'h0, 1'b0, 1'b1);
    tick();
    check("stat_bit3", bif.rd_data, 32'h8);

    // Pin 5 sets STAT regardless of IRQ_EN.
    idle();
    pin_in[5] = 1'b1;
    tick();
    tick();
    tick();
    bus(BASE + 4, 32'h0, 1'b0, 1'b1);
    tick();
    check("stat_bit5", bif.rd_data, 32'h28);
    check("irq_bit5",  {31'h0, irq}, 32'h1);

    // W1C of bit3 drops irq; bit5 stays.
    bus(BASE + 4, 32'h8, 1'b1, 1'b0);
    tick();
    check("w1c_irq", {31'h0, irq}, 32'h0);
    bus(BASE + 4, 32'h0, 1'b0, 1'b1);
    tick();
    check("w1c_stat", bif.rd_data, 32'h20);

    // Collision: re-arm STAT bit3, then clear it on the edge a new rise lands.
    idle();
    pin_in[3] = 1'b0;
    tick(); tick(); tick();
    pin_in[3] = 1'b1;
    tick(); tick(); tick();
    check("rearm_irq", {31'h0, irq}, 32'h1);
    pin_in[3] = 1'b0;
    tick(); tick(); tick();
    pin_in[3] = 1'b1;
    tick();                                   // edge k
    tick();                                   // edge k+1, rise now detected
    bus(BASE + 4, 32'h8, 1'b1, 1'b0);
    tick();                                   // edge k+2, set vs clear
    check("coll_irq", {31'h0, irq}, 32'h1);
    bus(BASE + 4, 32'h0, 1'b0, 1'b1);
    tick();
    check("coll_stat", bif.rd_data, 32'h28);

    // Reset mid-operation with a read pending and pin 0 held high.
    bus(BASE, 32'hFFFF, 1'b1, 1'b0);
    tick();
    check("pre_rst_out", out, 32'hFFFF);
    pin_in = 32'h1;
    bus(BASE, 32'h0, 1'b0, 1'b1);
    RST = 1'b1;
    tick();
    check("mid_rst_out",      out, 32'h0);
    check("mid_rst_oe",       oe,  32'h0);
    check("mid_rst_irq",      {31'h0, irq}, 32'h0);
    check("mid_rst_rd_valid", {31'h0, bif.rd_valid}, 32'h0);
    check("mid_rst_rd_data",  bif.rd_data, 32'h0);
    RST = 1'b0;
    bus(BASE + 3, 32'h1, 1'b1, 1'b0);
    tick();                                   // 1st edge after deassert
    check("post_rst_e1_irq", {31'h0, irq}, 32'h0);
    idle();
    tick();                                   // 2nd edge
    check("post_rst_e2_irq", {31'h0, irq}, 32'h0);
    tick();                                   // 3rd edge: STAT bit0 sets
    check("post_rst_e3_irq", {31'h0, irq}, 32'h1);
    bus(BASE + 4, 32'h0, 1'b0, 1'b1);
    tick();
    check("post_rst_stat", bif.rd_data, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_gpio_bank
